// File: rtl/mmu_tlb_search_ctrl.sv
// Sequential TLB search shared by IMMU and DMMU: round-robin grant, one entry
// read per two cycles, first (lowest-index) matching entry wins.
module mmu_tlb_search_ctrl #(
   parameter int ENTRY_NUM = 16,
   parameter int IDX_W     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_req,
   input  logic [31:0]      i_ea,
   input  logic             i_as,
   input  logic             d_req,
   input  logic [31:0]      d_ea,
   input  logic             d_as,
   input  logic [7:0]       PID0,
   input  logic [7:0]       PID1,
   input  logic [7:0]       PID2,
   input  logic             tlb_wr_busy,
   output logic             tlb_rd_en,
   output logic [IDX_W-1:0] tlb_rd_idx,
   input  logic             tlb_entry_V,
   input  logic             tlb_entry_TS,
   input  logic [7:0]       tlb_entry_TID,
   input  logic [19:0]      tlb_entry_EPN,
   output logic             i_done,
   output logic             d_done,
   output logic             hit,
   output logic [IDX_W-1:0] hit_idx,
   output logic             busy
);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_CMP, S_DONE} state_e;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRY_NUM - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [19:0]      epn_q, epn_d;
   logic             as_q, as_d;
   logic [7:0]       pid0_q, pid0_d, pid1_q, pid1_d, pid2_q, pid2_d;
   logic             side_q, side_d;   // 1 = DMMU owns the running search
   logic             last_q, last_d;   // 1 = DMMU won the last grant
   logic             hit_q, hit_d;
   logic [IDX_W-1:0] hit_idx_q, hit_idx_d;
   logic             grant_d, match;

   logic unused_ea;
   assign unused_ea = ^{i_ea[11:0], d_ea[11:0]};

   // On a tie, hand the search to whichever side did not win last time.
   assign grant_d = d_req && (!i_req || !last_q);

   assign match = tlb_entry_V && (tlb_entry_TS == as_q) && (tlb_entry_EPN == epn_q) &&
                  ((tlb_entry_TID == 8'd0) || (tlb_entry_TID == pid0_q) ||
                   (tlb_entry_TID == pid1_q) || (tlb_entry_TID == pid2_q));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         epn_q     <= '0;
         as_q      <= 1'b0;
         pid0_q    <= '0;
         pid1_q    <= '0;
         pid2_q    <= '0;
         side_q    <= 1'b0;
         last_q    <= 1'b0;
         hit_q     <= 1'b0;
         hit_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         epn_q     <= epn_d;
         as_q      <= as_d;
         pid0_q    <= pid0_d;
         pid1_q    <= pid1_d;
         pid2_q    <= pid2_d;
         side_q    <= side_d;
         last_q    <= last_d;
         hit_q     <= hit_d;
         hit_idx_q <= hit_idx_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      epn_d     = epn_q;
      as_d      = as_q;
      pid0_d    = pid0_q;
      pid1_d    = pid1_q;
      pid2_d    = pid2_q;
      side_d    = side_q;
      last_d    = last_q;
      hit_d     = hit_q;
      hit_idx_d = hit_idx_q;
      tlb_rd_en = 1'b0;
      i_done    = 1'b0;
      d_done    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (i_req || d_req) begin
               side_d  = grant_d;
               last_d  = grant_d;
               epn_d   = grant_d ? d_ea[31:12] : i_ea[31:12];
               as_d    = grant_d ? d_as : i_as;
               pid0_d  = PID0;
               pid1_d  = PID1;
               pid2_d  = PID2;
               idx_d   = '0;
               state_d = S_RD;
            end
         end
         S_RD: begin
            if (!tlb_wr_busy) begin
               tlb_rd_en = 1'b1;
               state_d   = S_CMP;
            end
         end
         S_CMP: begin
            // A concurrent tlbwe may have changed any entry: restart from 0.
            if (tlb_wr_busy) begin
               idx_d   = '0;
               state_d = S_RD;
            end else if (match) begin
               hit_d     = 1'b1;
               hit_idx_d = idx_q;
               state_d   = S_DONE;
            end else if (idx_q == LAST_IDX) begin
               hit_d     = 1'b0;
               hit_idx_d = '0;
               state_d   = S_DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = S_RD;
            end
         end
         S_DONE: begin
            i_done  = !side_q;
            d_done  = side_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign tlb_rd_idx = idx_q;
   assign hit        = hit_q;
   assign hit_idx    = hit_idx_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mmu_tlb_search_ctrl.sv
// Bench for mmu_tlb_search_ctrl: behavioural TLB array, scoreboard of expected
// done pulses, table of lookups plus arbitration/interlock/reset sequences.
module tb_mmu_tlb_search_ctrl;
   localparam int N = 16;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_req, d_req, i_as, d_as, tlb_wr_busy;
   logic [31:0]  i_ea, d_ea;
   logic [7:0]   PID0, PID1, PID2;
   logic         tlb_rd_en;
   logic [W-1:0] tlb_rd_idx;
   logic         tlb_entry_V = 1'b0, tlb_entry_TS = 1'b0;
   logic [7:0]   tlb_entry_TID = '0;
   logic [19:0]  tlb_entry_EPN = '0;
   logic         i_done, d_done, hit, busy;
   logic [W-1:0] hit_idx;

   mmu_tlb_search_ctrl #(.ENTRY_NUM(N), .IDX_W(W)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_ea(i_ea), .i_as(i_as),
      .d_req(d_req), .d_ea(d_ea), .d_as(d_as),
      .PID0(PID0), .PID1(PID1), .PID2(PID2),
      .tlb_wr_busy(tlb_wr_busy),
      .tlb_rd_en(tlb_rd_en), .tlb_rd_idx(tlb_rd_idx),
      .tlb_entry_V(tlb_entry_V), .tlb_entry_TS(tlb_entry_TS),
      .tlb_entry_TID(tlb_entry_TID), .tlb_entry_EPN(tlb_entry_EPN),
      .i_done(i_done), .d_done(d_done),
      .hit(hit), .hit_idx(hit_idx), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // TLB storage model: read data appears the cycle after the read strobe.
   logic        mV[N], mTS[N];
   logic [7:0]  mTID[N];
   logic [19:0] mEPN[N];
   always @(posedge clk)
      if (tlb_rd_en) begin
         tlb_entry_V   <= mV[tlb_rd_idx];
         tlb_entry_TS  <= mTS[tlb_rd_idx];
         tlb_entry_TID <= mTID[tlb_rd_idx];
         tlb_entry_EPN <= mEPN[tlb_rd_idx];
      end

   typedef struct { logic side; logic hit; logic [W-1:0] idx; int cyc; } exp_t;
   typedef struct { int cyc; int idx; } rd_t;
   typedef struct {
      logic side; logic [31:0] ea; logic as;
      logic [7:0] p0, p1, p2; logic hit; logic [W-1:0] idx;
   } vec_t;

   exp_t sbq[$];
   rd_t  rdlog[$];
   int   n_chk = 0, n_pass = 0, done_cnt = 0;

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
   endtask

   always @(negedge clk) if (rst && tlb_rd_en) rdlog.push_back('{cyc, int'(tlb_rd_idx)});

   // Scoreboard: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (i_done || d_done) begin
         exp_t e;
         done_cnt++;
         if (sbq.size() == 0) begin
            check("stray_done", int'({i_done, d_done}), 0);
         end else begin
            e = sbq.pop_front();
            check("done_side", int'({i_done, d_done}), e.side ? 1 : 2);
            check("hit", int'(hit), int'(e.hit));
            check("hit_idx", int'(hit_idx), int'(e.idx));
            check("done_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic wait_q(input int target, input int maxc, input string nm);
      for (int t = 0; t < maxc; t++) begin
         @(negedge clk); #2;
         if (sbq.size() <= target) return;
      end
      check(nm, sbq.size(), target);
      sbq.delete();
   endtask

   task automatic drive(input vec_t v);
      PID0 = v.p0; PID1 = v.p1; PID2 = v.p2;
      if (v.side) begin d_ea = v.ea; d_as = v.as; d_req = 1'b1; end
      else        begin i_ea = v.ea; i_as = v.as; i_req = 1'b1; end
   endtask

   task automatic run_vec(input vec_t v);
      int c0, nrd;
      bit ok;
      @(negedge clk);
      drive(v);
      c0 = cyc;
      rdlog.delete();
      sbq.push_back('{v.side, v.hit, v.idx, c0 + (v.hit ? 2 * int'(v.idx) + 3 : 2 * N + 1)});
      wait_q(0, 200, "vec_timeout");
      i_req = 1'b0; d_req = 1'b0;
      nrd = v.hit ? int'(v.idx) + 1 : N;
      ok = (rdlog.size() == nrd);
      foreach (rdlog[j])
         if (rdlog[j].idx != j || rdlog[j].cyc != c0 + 1 + 2 * j) ok = 1'b0;
      check("rd_seq", int'(ok), 1);
   endtask

   vec_t vt[10];

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int c0, dc;
      vec_t v;
      vt[0] = '{1'b0, 32'hAAAAA000, 1'b0, 8'd7, 8'd8, 8'd9, 1'b1, 4'd0};
      vt[1] = '{1'b0, 32'hAAAAA000, 1'b0, 8'd1, 8'd2, 8'd3, 1'b0, 4'd0};
      vt[2] = '{1'b1, 32'h12345000, 1'b0, 8'd7, 8'd8, 8'd9, 1'b1, 4'd2};
      vt[3] = '{1'b1, 32'h12345FFF, 1'b1, 8'd1, 8'd2, 8'd3, 1'b1, 4'd1};
      vt[4] = '{1'b0, 32'h55555000, 1'b0, 8'd5, 8'd0, 8'd0, 1'b1, 4'd3};
      vt[5] = '{1'b0, 32'h55555ABC, 1'b0, 8'd1, 8'd2, 8'd3, 1'b0, 4'd0};
      vt[6] = '{1'b1, 32'hFFFFF000, 1'b1, 8'd0, 8'd0, 8'd9, 1'b1, 4'd15};
      vt[7] = '{1'b1, 32'hFFFFF000, 1'b0, 8'd9, 8'd0, 8'd0, 1'b0, 4'd0};
      vt[8] = '{1'b0, 32'h00000123, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 4'd0};
      vt[9] = '{1'b0, 32'h77777000, 1'b0, 8'd1, 8'd2, 8'd3, 1'b1, 4'd5};

      for (int k = 0; k < N; k++) begin mV[k] = 0; mTS[k] = 0; mTID[k] = 0; mEPN[k] = 0; end
      mV[0] = 1; mTID[0] = 8;  mEPN[0] = 20'hAAAAA;
      mV[1] = 1; mTS[1] = 1;   mEPN[1] = 20'h12345;
      mV[2] = 1;               mEPN[2] = 20'h12345;
      mV[3] = 1; mTID[3] = 5;  mEPN[3] = 20'h55555;
                               mEPN[4] = 20'h55555;
      mV[5] = 1;               mEPN[5] = 20'h77777;
      mV[15] = 1; mTS[15] = 1; mTID[15] = 9; mEPN[15] = 20'hFFFFF;

      rst = 1'b0; i_req = 0; d_req = 0; i_as = 0; d_as = 0; tlb_wr_busy = 0;
      i_ea = '0; d_ea = '0; PID0 = '0; PID1 = '0; PID2 = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_rd_en", int'(tlb_rd_en), 0);
      check("rst_rd_idx", int'(tlb_rd_idx), 0);
      check("rst_i_done", int'(i_done), 0);
      check("rst_d_done", int'(d_done), 0);
      check("rst_hit", int'(hit), 0);
      check("rst_hit_idx", int'(hit_idx), 0);
      rst = 1'b1;

      // Tie right after reset goes to D; D stays requesting, so I wins the next tie.
      @(negedge clk);
      PID0 = 8'd5; PID1 = 8'd8; PID2 = 8'd9;
      i_ea = 32'hAAAAA000; i_as = 0; d_ea = 32'h12345000; d_as = 0;
      i_req = 1; d_req = 1; c0 = cyc;
      sbq.push_back('{1'b1, 1'b1, 4'd2, c0 + 7});
      sbq.push_back('{1'b0, 1'b1, 4'd0, c0 + 11});
      sbq.push_back('{1'b1, 1'b1, 4'd2, c0 + 19});
      wait_q(1, 200, "arb_timeout");
      i_req = 0;
      wait_q(0, 200, "arb_timeout");
      d_req = 0;

      foreach (vt[i]) run_vec(vt[i]);

      // Write interlock during RD: three stalled cycles, no read strobes.
      @(negedge clk);
      drive(vt[4]); c0 = cyc;
      sbq.push_back('{1'b0, 1'b1, 4'd3, c0 + 12});
      @(negedge clk); #1 tlb_wr_busy = 1; #1 check("rd_stall_en", int'(tlb_rd_en), 0);
      repeat (2) begin @(negedge clk); #1 check("rd_stall_en", int'(tlb_rd_en), 0); end
      @(negedge clk); #1 tlb_wr_busy = 0;
      #1 check("rd_resume_en", int'(tlb_rd_en), 1);
      check("rd_resume_idx", int'(tlb_rd_idx), 0);
      wait_q(0, 200, "rd_stall_timeout");
      i_req = 0;

      // Write interlock during CMP of entry 2: scan restarts from entry 0.
      @(negedge clk);
      drive(vt[4]); c0 = cyc;
      sbq.push_back('{1'b0, 1'b1, 4'd3, c0 + 15});
      repeat (6) @(negedge clk);
      check("cmp2_idx", int'(tlb_rd_idx), 2);
      #1 tlb_wr_busy = 1;
      @(negedge clk);
      check("rescan_idx", int'(tlb_rd_idx), 0);
      #1 tlb_wr_busy = 0;
      #1 check("rescan_en", int'(tlb_rd_en), 1);
      wait_q(0, 200, "cmp_stall_timeout");
      i_req = 0;

      // Reset during CMP of entry 5 aborts without a done pulse.
      @(negedge clk);
      v = vt[5];
      drive(v);
      repeat (12) @(negedge clk);
      check("pre_rst_idx", int'(tlb_rd_idx), 5);
      check("pre_rst_hit", int'(hit), 1);
      #1 rst = 1'b0;
      #1 check("abort_busy", int'(busy), 0);
      check("abort_rd_en", int'(tlb_rd_en), 0);
      check("abort_hit", int'(hit), 0);
      i_req = 0;
      dc = done_cnt;
      @(negedge clk); rst = 1'b1;
      repeat (40) @(negedge clk);
      check("abort_no_done", done_cnt, dc);
      check("abort_idle", int'(busy), 0);

      run_vec(vt[0]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
